// File: rtl/phase_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : phase_cmd_ctrl
//  Brief    : Byte-stream command processor for the phase oscillator bank.
//             Parses WRITE / READ / COMMIT frames from the UART receiver,
//             keeps a shadow bank of per-channel phase offsets and copies the
//             whole shadow bank to the active offset bus on COMMIT so every
//             channel changes phase on the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module phase_cmd_ctrl #(
    parameter int OUTPUTS  = 16,
    parameter int OFFSET_W = 24,
    parameter int TIMEOUT  = 50000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [OFFSET_W*OUTPUTS-1:0]  offsets,
    output logic                         reload,
    output logic                         busy
);

    // Frame geometry
    localparam int c_NB   = (OFFSET_W + 7) / 8;
    localparam int c_DW   = c_NB * 8;
    localparam int c_SH_W = (c_NB > 1) ? (c_NB - 1) * 8 : 8;
    localparam int c_CH_W = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
    localparam int c_NBW  = $clog2(c_NB + 1);
    localparam int c_TW   = $clog2(TIMEOUT + 1);

    localparam logic [8:0]        c_NCH      = 9'(OUTPUTS);
    localparam logic [c_TW-1:0]   c_TMO_LAST = c_TW'(TIMEOUT - 1);
    localparam logic [c_NBW-1:0]  c_LAST_B   = c_NBW'(c_NB - 1);

    // Protocol bytes
    localparam logic [7:0] c_OP_WRITE  = 8'h01;
    localparam logic [7:0] c_OP_READ   = 8'h02;
    localparam logic [7:0] c_OP_COMMIT = 8'h03;
    localparam logic [7:0] c_ACK       = 8'h06;
    localparam logic [7:0] c_NAK       = 8'h15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CHAN = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_wr;        // frame in progress is a WRITE
    logic [c_CH_W-1:0]      r_ch;        // addressed channel
    logic                   r_ch_ok;     // addressed channel exists
    logic [c_NBW-1:0]       r_cnt;       // data bytes received so far
    logic [c_TW-1:0]        r_tmo;       // idle cycles inside a frame
    logic [c_DW-1:0]        r_resp;      // remaining READ reply bytes
    logic [c_NBW-1:0]       r_left;      // reply bytes still to send after current
    logic [OFFSET_W-1:0]    r_shadow [OUTPUTS];
    logic [OFFSET_W-1:0]    r_active [OUTPUTS];

    logic                   w_rx_fire;
    logic                   w_tx_fire;
    logic                   w_ch_ok;
    logic [c_DW-1:0]        w_rd_val;
    logic [c_DW-1:0]        w_assembled;

    assign w_rx_fire = rx_valid && rx_ready;
    assign w_tx_fire = tx_valid && tx_ready;
    assign w_ch_ok   = ({1'b0, rx_data} < c_NCH);
    assign w_rd_val  = c_DW'(r_shadow[rx_data[c_CH_W-1:0]]);

    // Data assembly: earlier bytes sit in a shift register, the byte being
    // accepted now completes the value (MSB first).
    generate
        if (c_NB > 1) begin : g_shift
            logic [c_SH_W-1:0] r_shift;

            // Shift each accepted data byte into the assembly register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_shift <= '0;
                end else if (r_state == S_DATA && w_rx_fire) begin
                    r_shift <= c_SH_W'({r_shift, rx_data});
                end
            end

            assign w_assembled = {r_shift, rx_data};
        end else begin : g_noshift
            assign w_assembled = rx_data;
        end
    endgenerate

    // Active offset bus: each channel is driven straight from its register
    generate
        for (genvar j = 0; j < OUTPUTS; j++) begin : g_pack
            assign offsets[OFFSET_W*j +: OFFSET_W] = r_active[j];
        end
    endgenerate

    // Frame parser, shadow/active banks and reply sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_wr     <= 1'b0;
            r_ch     <= '0;
            r_ch_ok  <= 1'b0;
            r_cnt    <= '0;
            r_tmo    <= '0;
            r_resp   <= '0;
            r_left   <= '0;
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            reload   <= 1'b0;
            busy     <= 1'b0;
            for (int j = 0; j < OUTPUTS; j++) begin
                r_shadow[j] <= OFFSET_W'(j * 10);
                r_active[j] <= OFFSET_W'(j * 10);
            end
        end else begin
            reload <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    rx_ready <= 1'b1;
                    busy     <= 1'b0;
                    r_tmo    <= '0;
                    if (w_rx_fire) begin
                        if (rx_data == c_OP_WRITE || rx_data == c_OP_READ) begin
                            r_wr    <= (rx_data == c_OP_WRITE);
                            busy    <= 1'b1;
                            r_state <= S_CHAN;
                        end else begin
                            // COMMIT and unknown opcodes reply immediately
                            if (rx_data == c_OP_COMMIT) begin
                                r_active <= r_shadow;
                                reload   <= 1'b1;
                                tx_data  <= c_ACK;
                            end else begin
                                tx_data  <= c_NAK;
                            end
                            r_left   <= '0;
                            tx_valid <= 1'b1;
                            rx_ready <= 1'b0;
                            busy     <= 1'b1;
                            r_state  <= S_RESP;
                        end
                    end
                end

                S_CHAN: begin
                    if (w_rx_fire) begin
                        r_tmo <= '0;
                        if (r_wr) begin
                            r_ch    <= rx_data[c_CH_W-1:0];
                            r_ch_ok <= w_ch_ok;
                            r_cnt   <= '0;
                            r_state <= S_DATA;
                        end else begin
                            tx_valid <= 1'b1;
                            rx_ready <= 1'b0;
                            r_state  <= S_RESP;
                            if (w_ch_ok) begin
                                tx_data <= w_rd_val[c_DW-1 -: 8];
                                r_resp  <= w_rd_val << 8;
                                r_left  <= c_LAST_B;
                            end else begin
                                tx_data <= c_NAK;
                                r_left  <= '0;
                            end
                        end
                    end else if (r_tmo == c_TMO_LAST) begin
                        // Stalled partial frame: drop it without a reply
                        r_tmo   <= '0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_rx_fire) begin
                        r_tmo <= '0;
                        if (r_cnt == c_LAST_B) begin
                            // Out-of-range channels still consume all data bytes
                            if (r_ch_ok) begin
                                r_shadow[r_ch] <= w_assembled[OFFSET_W-1:0];
                                tx_data        <= c_ACK;
                            end else begin
                                tx_data        <= c_NAK;
                            end
                            r_left   <= '0;
                            tx_valid <= 1'b1;
                            rx_ready <= 1'b0;
                            r_state  <= S_RESP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_tmo   <= '0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                S_RESP: begin
                    // tx_data only moves on an accepted transfer
                    if (w_tx_fire) begin
                        if (r_left == '0) begin
                            tx_valid <= 1'b0;
                            rx_ready <= 1'b1;
                            busy     <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            tx_data <= r_resp[c_DW-1 -: 8];
                            r_resp  <= r_resp << 8;
                            r_left  <= r_left - 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phase_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phase_cmd_ctrl
//  Brief    : Self-checking bench for phase_cmd_ctrl: directed vector table,
//             hand-written multi-cycle sequences and random frames checked
//             against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_phase_cmd_ctrl;

    localparam int OUTPUTS  = 16;
    localparam int OFFSET_W = 24;
    localparam int TIMEOUT  = 64;
    localparam int NB       = (OFFSET_W + 7) / 8;
    localparam int OW       = OFFSET_W * OUTPUTS;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [7:0]          rx_data = 8'h00;
    logic                rx_valid = 1'b0;
    logic                rx_ready;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready = 1'b1;
    logic [OW-1:0]       offsets;
    logic                reload;
    logic                busy;

    always #5 clk = ~clk;

    phase_cmd_ctrl #(
        .OUTPUTS  (OUTPUTS),
        .OFFSET_W (OFFSET_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .offsets  (offsets),
        .reload   (reload),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level reference model
    // ------------------------------------------------------------------
    logic [OFFSET_W-1:0] m_shadow [OUTPUTS];
    logic [OFFSET_W-1:0] m_active [OUTPUTS];
    int                  m_commits = 0;
    logic [7:0]          frame_q[$];
    logic [7:0]          exp_q[$];
    logic [7:0]          got_q[$];

    task automatic model_reset();
        for (int j = 0; j < OUTPUTS; j++) begin
            m_shadow[j] = OFFSET_W'(j * 10);
            m_active[j] = OFFSET_W'(j * 10);
        end
    endtask

    task automatic model_frame();
        logic [8*NB-1:0] d;
        int ch;
        exp_q.delete();
        ch = (frame_q.size() > 1) ? int'(frame_q[1]) : 0;
        if (frame_q[0] == 8'h01) begin
            d = '0;
            for (int k = 0; k < NB; k++) d = (d << 8) | (8*NB)'(frame_q[2+k]);
            if (ch < OUTPUTS) begin
                m_shadow[ch] = d[OFFSET_W-1:0];
                exp_q.push_back(8'h06);
            end else begin
                exp_q.push_back(8'h15);
            end
        end else if (frame_q[0] == 8'h02) begin
            if (ch < OUTPUTS) begin
                d = (8*NB)'(m_shadow[ch]);
                for (int k = 0; k < NB; k++) exp_q.push_back(d[8*(NB-1-k) +: 8]);
            end else begin
                exp_q.push_back(8'h15);
            end
        end else if (frame_q[0] == 8'h03) begin
            for (int j = 0; j < OUTPUTS; j++) m_active[j] = m_shadow[j];
            m_commits++;
            exp_q.push_back(8'h06);
        end else begin
            exp_q.push_back(8'h15);
        end
    endtask

    task automatic chk_offsets(input string name);
        logic [OW-1:0] e;
        for (int j = 0; j < OUTPUTS; j++) e[OFFSET_W*j +: OFFSET_W] = m_active[j];
        n_checks++;
        if (offsets !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, offsets, e);
        end
    endtask

    // ------------------------------------------------------------------
    // Transmit-side ready driver and output monitors
    // ------------------------------------------------------------------
    logic hold_low  = 1'b0;
    logic rand_mode = 1'b0;
    logic in_rst    = 1'b1;
    int   reload_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (hold_low)       tx_ready = 1'b0;
        else if (rand_mode) tx_ready = ($urandom_range(0, 3) != 0);
        else                tx_ready = 1'b1;
    end

    logic          p_valid = 1'b0;
    logic          p_ready = 1'b0;
    logic [7:0]    p_data  = 8'h00;
    logic          p_reload = 1'b0;
    logic [OW-1:0] p_off   = '0;

    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
        if (!in_rst && p_valid && !p_ready) begin
            chk("tx_hold_valid", 64'(tx_valid), 64'd1);
            chk("tx_hold_data", 64'(tx_data), 64'(p_data));
        end
        if (!in_rst && offsets != p_off) chk("reload_align", 64'(reload), 64'd1);
        if (reload) begin
            chk("reload_single_cycle", 64'(p_reload), 64'd0);
            reload_cnt++;
        end
        p_valid  = tx_valid;
        p_ready  = tx_ready;
        p_data   = tx_data;
        p_reload = reload;
        p_off    = offsets;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            chk("rx_ready_wait", 64'(rx_ready), 64'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap);
        got_q.delete();
        foreach (frame_q[i]) send_byte(frame_q[i], $urandom_range(0, max_gap));
    endtask

    task automatic wait_replies(input int n);
        int t = 0;
        while (got_q.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reply(input string name);
        chk({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({name, "_byte"}, 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    task automatic chk_after_frame(input string name);
        chk_offsets({name, "_offsets"});
        chk({name, "_reload_count"}, 64'(reload_cnt), 64'(m_commits));
        chk({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_frame(input string name, input int max_gap);
        model_frame();
        send_frame(max_gap);
        wait_replies(exp_q.size());
        chk_reply(name);
        chk_after_frame(name);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [2:0]  n_in;
        logic [39:0] in_b;    // frame bytes, left-justified
        logic [1:0]  n_out;
        logic [23:0] out_b;   // reply bytes, left-justified
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] b;
        int t;
        int kind;

        vecs[0] = '{3'd5, 40'h01_03_12_34_56, 2'd1, 24'h06_00_00};
        vecs[1] = '{3'd1, 40'h03_00_00_00_00, 2'd1, 24'h06_00_00};
        vecs[2] = '{3'd2, 40'h02_03_00_00_00, 2'd3, 24'h12_34_56};
        vecs[3] = '{3'd5, 40'h01_10_AA_BB_CC, 2'd1, 24'h15_00_00};
        vecs[4] = '{3'd1, 40'h7F_00_00_00_00, 2'd1, 24'h15_00_00};
        vecs[5] = '{3'd2, 40'h02_20_00_00_00, 2'd1, 24'h15_00_00};
        vecs[6] = '{3'd2, 40'h02_0F_00_00_00, 2'd3, 24'h00_00_96};
        vecs[7] = '{3'd2, 40'h02_10_00_00_00, 2'd1, 24'h15_00_00};

        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_rx_ready", 64'(rx_ready), 64'd1);
        chk("rel_tx_valid", 64'(tx_valid), 64'd0);
        chk("rel_busy", 64'(busy), 64'd0);
        chk("rel_off_ch0", 64'(offsets[0 +: OFFSET_W]), 64'd0);
        chk("rel_off_ch1", 64'(offsets[OFFSET_W +: OFFSET_W]), 64'd10);
        chk("rel_off_ch15", 64'(offsets[OFFSET_W*15 +: OFFSET_W]), 64'd150);
        chk("rel_reload_count", 64'(reload_cnt), 64'd0);
        in_rst = 1'b0;

        // Table-driven directed frames
        for (int v = 0; v < 8; v++) begin
            frame_q.delete();
            for (int k = 0; k < int'(vecs[v].n_in); k++) frame_q.push_back(vecs[v].in_b[39-8*k -: 8]);
            model_frame();
            exp_q.delete();
            for (int k = 0; k < int'(vecs[v].n_out); k++) exp_q.push_back(vecs[v].out_b[23-8*k -: 8]);
            send_frame(0);
            wait_replies(exp_q.size());
            chk_reply($sformatf("vec%0d", v));
            chk_after_frame($sformatf("vec%0d", v));
        end
        chk("commit_ch3", 64'(offsets[OFFSET_W*3 +: OFFSET_W]), 64'h123456);

        // READ with tx_ready held low mid-reply
        frame_q = '{8'h02, 8'h03};
        model_frame();
        send_frame(0);
        t = 0;
        while (got_q.size() < 1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        hold_low = 1'b1;
        repeat (6) @(negedge clk);
        chk("stall_valid_held", 64'(tx_valid), 64'd1);
        hold_low = 1'b0;
        wait_replies(exp_q.size());
        chk_reply("stall_read");
        chk_after_frame("stall_read");

        // Timeout on a partial WRITE
        frame_q = '{8'h01, 8'h05, 8'hAA};
        send_frame(0);
        repeat (TIMEOUT - 5) @(negedge clk);
        chk("tmo_busy_before", 64'(busy), 64'd1);
        repeat (10) @(negedge clk);
        chk("tmo_busy_after", 64'(busy), 64'd0);
        chk("tmo_no_reply", 64'(got_q.size()), 64'd0);
        chk("tmo_rx_ready", 64'(rx_ready), 64'd1);
        frame_q = '{8'h02, 8'h05};
        run_frame("tmo_read", 0);

        // Random frames with random gaps and random transmit back-pressure
        rand_mode = 1'b1;
        for (int n = 0; n < 80; n++) begin
            frame_q.delete();
            kind = $urandom_range(0, 9);
            if (kind <= 3 || kind == 9) begin
                frame_q.push_back(8'h01);
                frame_q.push_back(8'((kind == 9) ? $urandom_range(0, OUTPUTS-1) : $urandom_range(0, 19)));
                for (int k = 0; k < NB; k++) frame_q.push_back(8'($urandom_range(0, 255)));
            end else if (kind <= 6) begin
                frame_q.push_back(8'h02);
                frame_q.push_back(8'($urandom_range(0, 19)));
            end else if (kind == 7) begin
                frame_q.push_back(8'h03);
            end else begin
                frame_q.push_back(8'($urandom_range(4, 255)));
            end
            run_frame("rand", 3);
        end
        rand_mode = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while in DATA
        frame_q = '{8'h01, 8'h07, 8'h11, 8'h22};
        send_frame(0);
        in_rst = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_data_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_data_rx_ready", 64'(rx_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        got_q.delete();
        repeat (3) @(negedge clk);
        in_rst = 1'b0;
        chk("rst_data_busy", 64'(busy), 64'd0);
        chk("rst_data_rx_ready_rel", 64'(rx_ready), 64'd1);
        chk_offsets("rst_data_offsets");
        chk("rst_data_no_reply", 64'(got_q.size()), 64'd0);

        // Reset while in RESP with the transmitter stalled
        hold_low = 1'b1;
        repeat (2) @(negedge clk);
        frame_q = '{8'h02, 8'h01};
        send_frame(0);
        t = 0;
        while (!tx_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rst_resp_started", 64'(tx_valid), 64'd1);
        in_rst = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_resp_tx_valid", 64'(tx_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold_low = 1'b0;
        got_q.delete();
        model_reset();
        repeat (10) @(negedge clk);
        chk("rst_resp_no_reply", 64'(got_q.size()), 64'd0);
        chk("rst_resp_tx_valid_rel", 64'(tx_valid), 64'd0);
        chk_offsets("rst_resp_offsets");
        in_rst = 1'b0;
        frame_q = '{8'h03};
        run_frame("post_rst_commit", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phase_cmd_ctrl.md
# phase_cmd_ctrl

Byte-stream command processor between the UART receiver/transmitter and the bank of per-transducer phase oscillators. It parses framed host commands to write and read back per-channel phase offsets in a shadow register bank. A commit command transfers the whole shadow bank to the active offset bus at once and pulses `reload`, so all channels change phase on the same cycle. Replaces the fixed reset-time offsets and the UART echo loop in the top level.

## Interface
- `OUTPUTS`, 16, number of oscillator channels (1..256)
- `OFFSET_W`, 24, bits per channel offset (8..32); `NB = ceil(OFFSET_W/8)` data bytes per offset
- `TIMEOUT`, 50000, idle clock cycles before a partial frame is discarded (≥2)
- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-high reset
- `rx_data` in 8: received byte
- `rx_valid` in 1: `rx_data` valid
- `rx_ready` out 1: block accepts byte; transfer when `rx_valid && rx_ready`
- `tx_data` out 8: response byte
- `tx_valid` out 1: `tx_data` valid
- `tx_ready` in 1: transmitter accepts; transfer when `tx_valid && tx_ready`
- `offsets` out `OFFSET_W*OUTPUTS`: active offsets, channel j at `[OFFSET_W*j +: OFFSET_W]`
- `reload` out 1: one-cycle high pulse when the active offsets change
- `busy` out 1: high whenever state ≠ IDLE

## Operation
- Frames, all multi-byte values MSB first:
  - WRITE: `0x01`, ch, NB data bytes -> shadow[ch]; reply `0x06` (ACK)
  - READ: `0x02`, ch -> reply NB bytes of shadow[ch]
  - COMMIT: `0x03` -> active ← shadow (all channels), `reload` pulse; reply `0x06`
  - Any other first byte -> reply `0x15` (NAK), no state change
- ch ≥ `OUTPUTS`: WRITE still consumes all NB data bytes, shadow unchanged, reply NAK; READ replies single NAK.
- Data assembly: bytes shifted into an NB*8-bit register; low `OFFSET_W` bits stored, excess upper bits discarded.
- States: IDLE -> CHAN (opcode 01/02) -> DATA (WRITE, counts NB bytes) -> RESP -> IDLE. COMMIT and unknown opcodes go IDLE -> RESP. READ goes CHAN -> RESP with NB bytes queued.
- RESP: drives `tx_valid`; advances to next byte on each accepted transfer; returns to IDLE after last byte is accepted.
- `rx_ready` = 1 in IDLE, CHAN, DATA; 0 in RESP. Bytes arriving during RESP wait in the UART and are not dropped.
- Timeout: in CHAN or DATA, a counter increments each cycle without an accepted byte and clears on each accepted byte. When it reaches `TIMEOUT`, the block returns to IDLE silently, with no reply and no shadow write.
- Reset values: shadow[j] = active[j] = `j*10` (truncated to `OFFSET_W`); state IDLE; `rx_ready`=0 during reset, 1 on first cycle after; `tx_valid`=0; `tx_data`=0; `reload`=0; `busy`=0; timeout counter 0.
- Reset asserted mid-frame or mid-reply: the frame is abandoned, all registers take reset values, and no reply byte is emitted after release.

## Timing
- All outputs registered.
- WRITE: shadow updated in the cycle after the last data byte is accepted; `tx_valid` rises that same cycle.
- COMMIT: `offsets` change and `reload` is high for exactly one cycle, both in the cycle after the opcode is accepted; `tx_valid` rises the same cycle.
- READ: first reply byte is valid the cycle after the ch byte is accepted. `tx_data` changes only after an accepted transfer and is held stable while `tx_valid && !tx_ready`.
- Back-to-back frames: the next opcode may be accepted the cycle after the last reply byte transfers.
- Minimum WRITE turnaround: NB+2 accepted bytes + 1 cycle + reply handshake.

## Test plan
- Reset release: `offsets` ch0=0, ch1=10, ch15=150; `rx_ready`=1; `tx_valid`=0; `reload` never pulses.
- WRITE 01 03 12 34 56 -> ACK 0x06; `offsets` unchanged. Then COMMIT 03 -> ACK; ch3 = 0x123456; `reload` high exactly 1 cycle, aligned with the `offsets` change; other channels keep reset values.
- READ 02 03 after the above WRITE -> reply bytes 12, 34, 56, with `tx_ready` held low for 5 cycles mid-reply; data must hold stable throughout.
- WRITE 01 10 AA BB CC with OUTPUTS=16 (ch 16) -> NAK 0x15; shadow unchanged. Opcode 0x7F -> NAK. READ 02 20 -> single NAK.
- Timeout: send 01 05 AA, then idle for `TIMEOUT` cycles -> no reply, `busy` falls. A following READ 02 05 returns 00 00 32 (reset value 50).
- Assert `rst` in DATA and again in RESP -> `tx_valid` 0, no further reply bytes; all offsets back to `j*10`; next COMMIT produces one ACK.
